// File: rtl/decode_stage_buf.sv
// decode_stage_buf: registered RV32 decode stage with a 2-entry skid buffer and flush.
module decode_stage_buf #(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter bit ENABLE_AMO = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic [4:0]      out_func5,
  output logic            out_fun7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_type,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal
);
  typedef struct packed {
    logic [4:0]      opcode;
    logic [2:0]      func3;
    logic [4:0]      func5;
    logic            fun7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
    logic [PC_W-1:0] pc;
    logic            illegal;
  } entry_t;
  entry_t dec, o, s;
  logic o_valid, s_valid, accept, known;
  logic [4:0] op;
  logic [2:0] typ_raw, typ;
  logic signed [31:0] imm32;
  assign op = in_inst[6:2];
  assign typ_raw = (op == 5'b00000 || op == 5'b00011 || op == 5'b00100 || op == 5'b11001 || op == 5'b11100) ? 3'd1 :
                   op == 5'b01000 ? 3'd2 :
                   op == 5'b11000 ? 3'd3 :
                   (op == 5'b00101 || op == 5'b01101) ? 3'd4 :
                   op == 5'b11011 ? 3'd5 : 3'd0;
  assign known = typ_raw != 3'd0 || op == 5'b01100 || (op == 5'b01011 && ENABLE_AMO);
  always_comb begin
    dec = '0;
    dec.illegal = in_inst[1:0] != 2'b11 || !known;
    typ = dec.illegal ? 3'd0 : typ_raw;
    imm32 = typ == 3'd1 ? {{20{in_inst[31]}}, in_inst[31:20]} :
            typ == 3'd2 ? {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]} :
            typ == 3'd3 ? {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0} :
            typ == 3'd4 ? {in_inst[31:12], 12'b0} :
            typ == 3'd5 ? {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0} : 32'sd0;
    dec.opcode = op;
    dec.func3 = in_inst[14:12];
    dec.func5 = in_inst[31:27];
    dec.fun7 = in_inst[30];
    dec.rs1 = in_inst[19:15];
    dec.rs2 = in_inst[24:20];
    dec.rd = in_inst[11:7];
    dec.imm = XLEN'(imm32);
    dec.imm_type = typ;
    dec.pc = in_pc;
  end
  assign in_ready = !s_valid;
  assign accept = in_valid && in_ready && !flush;
  // While S is valid in_ready is low, so an advancing O never needs to refill S.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      s_valid <= 1'b0;
      o <= '0;
      s <= '0;
    end else if (flush) begin
      o_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!o_valid || out_ready) begin
      o_valid <= s_valid || accept;
      s_valid <= 1'b0;
      if (s_valid) o <= s;
      else if (accept) o <= dec;
    end else if (accept) begin
      s_valid <= 1'b1;
      s <= dec;
    end
  end
  assign out_valid = o_valid;
  assign out_opcode = o.opcode;
  assign out_func3 = o.func3;
  assign out_func5 = o.func5;
  assign out_fun7 = o.fun7;
  assign out_rs1 = o.rs1;
  assign out_rs2 = o.rs2;
  assign out_rd = o.rd;
  assign out_imm = o.imm;
  assign out_imm_type = o.imm_type;
  assign out_pc = o.pc;
  assign out_illegal = o.illegal;
endmodule

// File: tb/tb_decode_stage_buf.sv
// tb_decode_stage_buf: directed scoreboard bench; a second instance runs with AMO disabled.
module tb_decode_stage_buf;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic [31:0] in_inst = '0, in_pc = '0;
  logic in_ready, out_valid, out_fun7, out_illegal;
  logic [4:0] out_opcode, out_func5, out_rs1, out_rs2, out_rd;
  logic [2:0] out_func3, out_imm_type;
  logic [31:0] out_imm, out_pc;
  logic b_in_ready, b_out_valid, b_fun7, b_illegal;
  logic [4:0] b_opcode, b_func5, b_rs1, b_rs2, b_rd;
  logic [2:0] b_func3, b_imm_type;
  logic [31:0] b_imm, b_pc;
  typedef struct {
    logic [31:0] inst, pc, imm;
    logic [2:0] t;
    logic ill, ill1;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  decode_stage_buf #(.XLEN(32), .PC_W(32), .ENABLE_AMO(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_func3(out_func3), .out_func5(out_func5), .out_fun7(out_fun7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_imm_type(out_imm_type), .out_pc(out_pc), .out_illegal(out_illegal));
  decode_stage_buf #(.XLEN(32), .PC_W(32), .ENABLE_AMO(0)) dut_noamo (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_opcode(b_opcode), .out_func3(b_func3), .out_func5(b_func5), .out_fun7(b_fun7),
    .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm),
    .out_imm_type(b_imm_type), .out_pc(b_pc), .out_illegal(b_illegal));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [31:0] inst, pc, imm, input logic [2:0] t, input logic ill, ill1);
    in_valid = 1;
    in_inst = inst;
    in_pc = pc;
    cur = '{inst, pc, imm, t, ill, ill1};
  endtask
  task automatic step();
    exp_t e;
    if (!flush && out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_output", {32'd0, out_pc}, 64'hdead);
      else begin
        e = q.pop_front();
        chk("opcode", 64'(out_opcode), 64'(e.inst[6:2]));
        chk("func3", 64'(out_func3), 64'(e.inst[14:12]));
        chk("func5", 64'(out_func5), 64'(e.inst[31:27]));
        chk("fun7", 64'(out_fun7), 64'(e.inst[30]));
        chk("rs1", 64'(out_rs1), 64'(e.inst[19:15]));
        chk("rs2", 64'(out_rs2), 64'(e.inst[24:20]));
        chk("rd", 64'(out_rd), 64'(e.inst[11:7]));
        chk("imm", 64'(out_imm), 64'(e.imm));
        chk("imm_type", 64'(out_imm_type), 64'(e.t));
        chk("pc", 64'(out_pc), 64'(e.pc));
        chk("illegal", 64'(out_illegal), 64'(e.ill));
        chk("noamo_valid", 64'(b_out_valid), 64'd1);
        chk("noamo_illegal", 64'(b_illegal), 64'(e.ill1));
      end
    end
    if (!flush && in_valid && in_ready) q.push_back(cur);
    if (flush) q.delete();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    in_valid = 0;
    step();
  endtask
  initial begin
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imm", 64'(out_imm), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_opcode", 64'(out_opcode), 64'd0);
    @(posedge clk);
    #1;
    rst = 0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    drive(32'hFFB10093, 32'h100, 32'hFFFFFFFB, 3'd1, 0, 0);
    step();
    chk("addi_latency", 64'(out_valid), 64'd1);
    drive(32'hFE000EE3, 32'h104, 32'hFFFFFFFC, 3'd3, 0, 0); step();
    chk("stream_in_ready", 64'(in_ready), 64'd1);
    drive(32'h0080006F, 32'h108, 32'h8, 3'd5, 0, 0); step();
    drive(32'h123450B7, 32'h10C, 32'h12345000, 3'd4, 0, 0); step();
    drive(32'hFE20AE23, 32'h110, 32'hFFFFFFFC, 3'd2, 0, 0); step();
    drive(32'h0820A2AF, 32'h114, 32'h0, 3'd0, 0, 1); step();
    drive(32'h00000010, 32'h118, 32'h0, 3'd0, 1, 1); step();
    drive(32'h002081B3, 32'h11C, 32'h0, 3'd0, 0, 0); step();
    drive(32'h0000007F, 32'h120, 32'h0, 3'd0, 1, 1); step();
    idle(); idle();
    chk("stream_drained", 64'(q.size()), 64'd0);
    chk("stream_idle", 64'(out_valid), 64'd0);
    out_ready = 0;
    drive(32'h00100093, 32'h200, 32'h1, 3'd1, 0, 0); step();
    drive(32'h00200113, 32'h204, 32'h2, 3'd1, 0, 0); step();
    drive(32'h00300193, 32'h208, 32'h3, 3'd1, 0, 0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_pc", 64'(out_pc), 64'h200);
    chk("bp_stall", 64'(in_ready), 64'd0);
    out_ready = 1;
    step();
    chk("bp_b_next", 64'(out_pc), 64'h204);
    step();
    chk("bp_c_next", 64'(out_pc), 64'h208);
    idle();
    chk("bp_drained", 64'(q.size()), 64'd0);
    chk("bp_empty", 64'(out_valid), 64'd0);
    out_ready = 0;
    drive(32'h00400213, 32'h300, 32'h4, 3'd1, 0, 0); step();
    drive(32'h00500293, 32'h304, 32'h5, 3'd1, 0, 0); step();
    drive(32'h00600313, 32'h308, 32'h6, 3'd1, 0, 0);
    flush = 1;
    step();
    flush = 0;
    in_valid = 0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1;
    idle(); idle(); idle();
    chk("flush_no_leak", 64'(out_valid), 64'd0);
    out_ready = 0;
    drive(32'h00700393, 32'h400, 32'h7, 3'd1, 0, 0); step();
    drive(32'h00800413, 32'h404, 32'h8, 3'd1, 0, 0); step();
    in_valid = 0;
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    #2;
    rst = 1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_imm", 64'(out_imm), 64'd0);
    chk("arst_pc", 64'(out_pc), 64'd0);
    chk("arst_rd", 64'(out_rd), 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 0;
    out_ready = 1;
    drive(32'h00900493, 32'h500, 32'h9, 3'd1, 0, 0); step();
    chk("post_rst_latency", 64'(out_valid), 64'd1);
    idle(); idle();
    chk("final_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
